// File: rtl/vic_multi.sv
// vic_multi: N-channel vectored interrupt controller. Channels are edge or level, maskable, and the IAKO cycle is answered with a vector and a per-channel iack.
// Priority is fixed (lowest index wins) by default; define VIC_RR_EN for round-robin arbitration.
module vic_multi #(
   parameter int unsigned  N        = 4,
   parameter logic [N-1:0] EDGE     = {N{1'b1}},
   parameter logic [15:0]  SPUR_VEC = 16'o000000
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic            ce,
   input  logic [16*N-1:0] ivec,
   input  logic [N-1:0]    ireq,
   output logic [N-1:0]    iack,
   output logic            irq_o,
   input  logic            stb_i,
   output logic [15:0]     dat_o,
   output logic            ack_o,
   input  logic            msk_we,
   input  logic [N-1:0]    msk_din,
   output logic [N-1:0]    msk_o
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t         state_q;
   logic [N-1:0]   req_q;
   logic [N-1:0]   pend_q, pend_d;
   logic [N-1:0]   mask_q, mask_d;
   logic [N-1:0]   iack_q;
   logic           msk_we_q;
   logic           irq_q;
   logic           ack_q;
   logic [15:0]    dat_q;

   logic           msk_wr;
   logic [N-1:0]   pend;
   logic [N-1:0]   act;
   logic [N-1:0]   rise;
   logic [N-1:0]   grant;
   logic [N-1:0]   clr;
   logic           found;
   logic [IW-1:0]  win;
   logic [15:0]    win_vec;
   logic           take;

`ifdef VIC_RR_EN
   logic [IW-1:0]  rr_q, rr_d;
   int unsigned    rr_idx;
`endif

   // A mask write lands on the same ce as the act evaluation it affects.
   always_comb begin
      msk_wr = ce & msk_we & ~msk_we_q;
      mask_d = msk_wr ? msk_din : mask_q;
      for (int i = 0; i < N; i++) begin
         pend[i] = EDGE[i] ? pend_q[i] : ireq[i];
      end
      act  = pend & ~mask_d;
      rise = ireq & ~req_q & EDGE;
   end

   // Scan from highest offset down so the last hit is the preferred channel.
   always_comb begin
      found = 1'b0;
      win   = '0;
`ifdef VIC_RR_EN
      rr_idx = 0;
      for (int k = N - 1; k >= 0; k--) begin
         rr_idx = (int'(rr_q) + k) % N;
         if (act[rr_idx[IW-1:0]]) begin
            found = 1'b1;
            win   = rr_idx[IW-1:0];
         end
      end
      rr_d = (win == IW'(N - 1)) ? '0 : win + 1'b1;
`else
      for (int k = N - 1; k >= 0; k--) begin
         if (act[k]) begin
            found = 1'b1;
            win   = IW'(k);
         end
      end
`endif
   end

   always_comb begin
      grant   = '0;
      win_vec = SPUR_VEC;
      for (int k = 0; k < N; k++) begin
         if (found && (win == IW'(k))) begin
            grant[k] = 1'b1;
            win_vec  = ivec[16*k +: 16];
         end
      end
      take   = (state_q == S_IDLE) & stb_i;
      clr    = take ? grant : '0;
      // A fresh edge on the ack cycle re-arms the channel.
      pend_d = ((pend_q & ~clr) | rise) & EDGE;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         req_q    <= '0;
         pend_q   <= '0;
         mask_q   <= '0;
         iack_q   <= '0;
         msk_we_q <= 1'b0;
         irq_q    <= 1'b0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
`ifdef VIC_RR_EN
         rr_q     <= '0;
`endif
      end else begin
         iack_q <= '0;
         if (ce) begin
            req_q    <= ireq;
            msk_we_q <= msk_we;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            case (state_q)
               S_IDLE: begin
                  if (stb_i) begin
                     dat_q   <= found ? win_vec : SPUR_VEC;
                     iack_q  <= grant;
                     ack_q   <= 1'b1;
                     irq_q   <= 1'b0;
                     state_q <= S_ACK;
`ifdef VIC_RR_EN
                     if (found) begin
                        rr_q <= rr_d;
                     end
`endif
                  end else begin
                     irq_q <= |act;
                  end
               end
               S_ACK: begin
                  if (!stb_i) begin
                     ack_q   <= 1'b0;
                     irq_q   <= |act;
                     state_q <= S_IDLE;
                  end else begin
                     irq_q <= 1'b0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign iack  = iack_q;
   assign irq_o = irq_q;
   assign dat_o = dat_q;
   assign ack_o = ack_q;
   assign msk_o = mask_q;

endmodule

// File: tb/tb_vic_multi.sv
// Bench for vic_multi (N=4, ch0/ch1 edge, ch2/ch3 level): directed scenarios then random traffic.
// Every output is compared each clock against a transaction-level reference model.
module tb_vic_multi;

   localparam logic [63:0] IVEC = {16'o310, 16'o100, 16'o274, 16'o060};

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce;
   logic [3:0]  ireq;
   logic [3:0]  iack;
   logic        irq_o;
   logic        stb_i;
   logic [15:0] dat_o;
   logic        ack_o;
   logic        msk_we;
   logic [3:0]  msk_din;
   logic [3:0]  msk_o;

   int n_chk = 0;
   int n_err = 0;

   vic_multi #(.N(4), .EDGE(4'b0011), .SPUR_VEC(16'o000000)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ce      (ce),
      .ivec    (IVEC),
      .ireq    (ireq),
      .iack    (iack),
      .irq_o   (irq_o),
      .stb_i   (stb_i),
      .dat_o   (dat_o),
      .ack_o   (ack_o),
      .msk_we  (msk_we),
      .msk_din (msk_din),
      .msk_o   (msk_o)
   );

   always #5 clk_sys = ~clk_sys;

   // Reference model: per-channel bookkeeping in plain arrays.
   int vec_tab [4] = '{16'o060, 16'o274, 16'o100, 16'o310};
   bit is_edge [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   bit latched [4];
   bit last_req [4];
   bit masked [4];
   bit iack_m [4];
   bit last_mwe;
   bit busy;
   bit irq_m;
   bit ack_m;
   int dat_m;
   int rr_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0o, expected %0o (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         latched[i]  = 1'b0;
         last_req[i] = 1'b0;
         masked[i]   = 1'b0;
         iack_m[i]   = 1'b0;
      end
      last_mwe = 1'b0;
      busy     = 1'b0;
      irq_m    = 1'b0;
      ack_m    = 1'b0;
      dat_m    = 0;
      rr_m     = 0;
   endfunction

   function automatic void model_clock();
      bit visible [4];
      bit any;
      int w;
      int start;
      int idx;
      for (int i = 0; i < 4; i++) iack_m[i] = 1'b0;
      if (!ce) return;
      if (msk_we && !last_mwe) begin
         for (int i = 0; i < 4; i++) masked[i] = msk_din[i];
      end
      last_mwe = msk_we;
      any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         visible[i] = (is_edge[i] ? latched[i] : ireq[i]) && !masked[i];
         if (visible[i]) any = 1'b1;
      end
      if (busy) begin
         if (!stb_i) begin
            busy  = 1'b0;
            ack_m = 1'b0;
            irq_m = any;
         end
      end else if (stb_i) begin
`ifdef VIC_RR_EN
         start = rr_m;
`else
         start = 0;
`endif
         w = -1;
         for (int k = 0; k < 4; k++) begin
            idx = (start + k) % 4;
            if (w < 0 && visible[idx]) w = idx;
         end
         if (w >= 0) begin
            dat_m      = vec_tab[w];
            iack_m[w]  = 1'b1;
            latched[w] = 1'b0;
            rr_m       = (w + 1) % 4;
         end else begin
            dat_m = 0;
         end
         busy  = 1'b1;
         ack_m = 1'b1;
         irq_m = 1'b0;
      end else begin
         irq_m = any;
      end
      for (int i = 0; i < 4; i++) begin
         if (is_edge[i] && ireq[i] && !last_req[i]) latched[i] = 1'b1;
         last_req[i] = ireq[i];
      end
   endfunction

   task automatic step();
      logic [3:0] exp_iack;
      logic [3:0] exp_msk;
      @(posedge clk_sys);
      model_clock();
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_iack[i] = iack_m[i];
         exp_msk[i]  = masked[i];
      end
      check("irq", irq_o, irq_m);
      check("ack", ack_o, ack_m);
      check("dat", dat_o, dat_m);
      check("iack", iack, exp_iack);
      check("msk", msk_o, exp_msk);
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1; ireq = '0; stb_i = 1'b0; msk_we = 1'b0; msk_din = '0;
      model_reset();
      #23;
      check("rst_irq", irq_o, 0);
      check("rst_dat", dat_o, 0);
      check("rst_ack", ack_o, 0);
      check("rst_iack", iack, 0);
      check("rst_msk", msk_o, 0);
      reset = 1'b0;

      // Edge request on ch1 and its IAKO cycle
      ireq = 4'b0010; step(); ireq = '0; step();
      check("t1_irq", irq_o, 1);
      stb_i = 1'b1; step();
      check("t1_dat", dat_o, 16'o274);
      check("t1_ack", ack_o, 1);
      check("t1_iack", iack, 4'b0010);
      step();
      check("t1_iack_once", iack, 0);
      check("t1_irq_in_ack", irq_o, 0);
      stb_i = 1'b0; step();
      check("t1_ack_rel", ack_o, 0);
      check("t1_irq_after", irq_o, 0);
      check("t1_dat_hold", dat_o, 16'o274);

      // Simultaneous ch0+ch1
      ireq = 4'b0011; step(); ireq = '0; step();
      stb_i = 1'b1; step();
      check("t2_first", dat_o, 16'o060);
      stb_i = 1'b0; step();
      check("t2_irq_left", irq_o, 1);
      stb_i = 1'b1; step();
      check("t2_second", dat_o, 16'o274);
      stb_i = 1'b0; step();
`ifdef VIC_RR_EN
      ireq = 4'b0001; step(); ireq = '0; step();
      stb_i = 1'b1; step(); stb_i = 1'b0; step();
      ireq = 4'b0011; step(); ireq = '0; step();
      stb_i = 1'b1; step();
      check("t2_rr_first", dat_o, 16'o274);
      stb_i = 1'b0; step(); stb_i = 1'b1; step();
      check("t2_rr_second", dat_o, 16'o060);
      stb_i = 1'b0; step();
`endif

      // Masked edge channel latches and appears on unmask
      msk_we = 1'b1; msk_din = 4'b0001; step(); msk_we = 1'b0;
      check("t3_msk", msk_o, 4'b0001);
      ireq = 4'b0001; step(); ireq = '0; step(); step();
      check("t3_masked", irq_o, 0);
      msk_we = 1'b1; msk_din = 4'b0000; step(); msk_we = 1'b0;
      check("t3_unmask", irq_o, 1);
      stb_i = 1'b1; step();
      check("t3_vec", dat_o, 16'o060);
      stb_i = 1'b0; step();

      // Level channel 2
      ireq = 4'b0100; step();
      check("t4_irq", irq_o, 1);
      stb_i = 1'b1; step();
      check("t4_vec", dat_o, 16'o100);
      check("t4_iack", iack, 4'b0100);
      ireq = '0; step();
      stb_i = 1'b0; step();
      check("t4_irq_drop", irq_o, 0);

      // Spurious IAKO
      stb_i = 1'b1; step();
      check("t5_dat", dat_o, 0);
      check("t5_ack", ack_o, 1);
      check("t5_iack", iack, 0);
      stb_i = 1'b0; step();

      // Reset while in ACK with two edge channels pending
      ireq = 4'b0011; step(); ireq = '0; step();
      stb_i = 1'b1; step();
      ireq = 4'b0001; step(); ireq = '0; step();
      check("t6_in_ack", ack_o, 1);
      reset = 1'b1;
      #1;
      check("t6_irq", irq_o, 0);
      check("t6_dat", dat_o, 0);
      check("t6_ack", ack_o, 0);
      check("t6_iack", iack, 0);
      model_reset();
      reset = 1'b0; stb_i = 1'b0;
      step(); step(); step();
      check("t6_no_irq", irq_o, 0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         ce = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 4; i++) ireq[i] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) stb_i = ~stb_i;
         msk_we  = ($urandom_range(0, 7) == 0);
         msk_din = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
